// File: rtl/uart_baud_gen_os.sv
// Oversampling UART baud generator: os_tick (OSR x baud), baud_tick, mid_tick.
// Latency: all ticks are registered, high in the cycle after the period counter wraps.
// Backpressure: cfg_ready is low while a divisor is pending, until it is applied.
// Optional feature: define UART_BAUD_FRAC_EN for the fractional divisor accumulator.
module uart_baud_gen_os #(
  parameter int unsigned CLK_FREQ     = 50_000_000,
  parameter int unsigned DEFAULT_BAUD = 9600,
  parameter int unsigned OSR          = 16,
  parameter int unsigned DIV_W        = 16,
  parameter int unsigned FRAC_W       = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              restart,
  input  logic [DIV_W-1:0]  cfg_div_int,
  input  logic [FRAC_W-1:0] cfg_div_frac,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              os_tick,
  output logic              baud_tick,
  output logic              mid_tick,
  output logic              cfg_err
);

  localparam int unsigned       OS_W    = (OSR > 1) ? $clog2(OSR) : 1;
  localparam logic [OS_W-1:0]   OS_LAST = OS_W'(OSR - 1);
  localparam logic [OS_W-1:0]   OS_MID  = OS_W'(OSR / 2 - 1);
  localparam logic [63:0]       BAUD_OS = 64'(DEFAULT_BAUD) * 64'(OSR);
`ifdef UART_BAUD_FRAC_EN
  // Rounded fixed-point divisor: integer part above FRAC_W, fraction below.
  localparam logic [63:0]       Q_DEF    = ((64'(CLK_FREQ) << FRAC_W) + BAUD_OS / 64'd2) / BAUD_OS;
  localparam logic [DIV_W-1:0]  DEF_INT  = DIV_W'(Q_DEF >> FRAC_W);
  localparam logic [FRAC_W-1:0] DEF_FRAC = FRAC_W'(Q_DEF);
`else
  localparam logic [63:0]       Q_DEF    = (64'(CLK_FREQ) + BAUD_OS / 64'd2) / BAUD_OS;
  localparam logic [DIV_W-1:0]  DEF_INT  = DIV_W'(Q_DEF);
`endif

  logic [DIV_W-1:0] div_int_q,  div_int_d;
  logic [DIV_W-1:0] pend_int_q, pend_int_d;
  logic [DIV_W-1:0] cnt_q,      cnt_d;
  logic [OS_W-1:0]  os_cnt_q,   os_cnt_d;
  logic             pend_q,     pend_d;
  logic             cfg_ready_q, cfg_ready_d;
  logic             cfg_err_q,   cfg_err_d;
  logic             os_tick_q,   os_tick_d;
  logic             baud_tick_q, baud_tick_d;
  logic             mid_tick_q,  mid_tick_d;
  logic             apply;
  logic             cfg_accept;
  logic             cfg_bad;
  logic [DIV_W:0]   period_last;
  logic             wrap;

`ifdef UART_BAUD_FRAC_EN
  logic [FRAC_W-1:0] div_frac_q,  div_frac_d;
  logic [FRAC_W-1:0] pend_frac_q, pend_frac_d;
  logic [FRAC_W-1:0] acc_q,       acc_d;
  logic              ext_q,       ext_d;
  logic [FRAC_W:0]   acc_sum;

  assign acc_sum     = {1'b0, acc_q} + {1'b0, div_frac_q};
  // Current period is div_int cycles, stretched by one when the last wrap carried.
  assign period_last = {1'b0, div_int_q} + {{DIV_W{1'b0}}, ext_q} - {{DIV_W{1'b0}}, 1'b1};
`else
  logic cfg_frac_unused;

  assign cfg_frac_unused = ^cfg_div_frac;
  assign period_last     = {1'b0, div_int_q} - {{DIV_W{1'b0}}, 1'b1};
`endif

  assign cfg_accept = cfg_valid && cfg_ready_q;
  assign cfg_bad    = (cfg_div_int < DIV_W'(2));
  assign wrap       = ({1'b0, cnt_q} == period_last);

  // Next-state: config capture, restart/enable handling, period and oversample counting.
  always_comb begin
    div_int_d   = div_int_q;
    pend_int_d  = pend_int_q;
    cnt_d       = cnt_q;
    os_cnt_d    = os_cnt_q;
    pend_d      = pend_q;
    cfg_err_d   = cfg_err_q;
    os_tick_d   = 1'b0;
    baud_tick_d = 1'b0;
    mid_tick_d  = 1'b0;
    apply       = 1'b0;
`ifdef UART_BAUD_FRAC_EN
    div_frac_d  = div_frac_q;
    pend_frac_d = pend_frac_q;
    acc_d       = acc_q;
    ext_d       = ext_q;
`endif

    if (cfg_accept) begin
      if (cfg_bad) begin
        cfg_err_d = 1'b1;
      end else begin
        pend_d     = 1'b1;
        pend_int_d = cfg_div_int;
`ifdef UART_BAUD_FRAC_EN
        pend_frac_d = cfg_div_frac;
`endif
      end
    end

    if (restart) begin
      // Re-align to an RX edge; a request accepted this same cycle takes effect now.
      cnt_d    = '0;
      os_cnt_d = '0;
`ifdef UART_BAUD_FRAC_EN
      acc_d    = '0;
      ext_d    = 1'b0;
`endif
      apply    = pend_d;
    end else if (en) begin
      if (wrap) begin
        cnt_d       = '0;
        os_tick_d   = 1'b1;
        baud_tick_d = (os_cnt_q == OS_LAST);
        mid_tick_d  = (os_cnt_q == OS_MID);
        os_cnt_d    = (os_cnt_q == OS_LAST) ? '0 : os_cnt_q + OS_W'(1);
`ifdef UART_BAUD_FRAC_EN
        acc_d       = acc_sum[FRAC_W-1:0];
        ext_d       = acc_sum[FRAC_W];
`endif
        apply       = pend_q;
      end else begin
        cnt_d = cnt_q + DIV_W'(1);
      end
    end else begin
      // Counters are frozen, so a pending divisor can be swapped in straight away.
      apply = pend_q;
    end

    if (apply) begin
      div_int_d = pend_int_d;
      cnt_d     = '0;
      pend_d    = 1'b0;
`ifdef UART_BAUD_FRAC_EN
      div_frac_d = pend_frac_d;
      acc_d      = '0;
      ext_d      = 1'b0;
`endif
    end

    cfg_ready_d = !pend_d;
  end

  // State and registered outputs; reset reloads the default divisor and drops any request.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_int_q   <= DEF_INT;
      pend_int_q  <= '0;
      cnt_q       <= '0;
      os_cnt_q    <= '0;
      pend_q      <= 1'b0;
      cfg_ready_q <= 1'b1;
      cfg_err_q   <= 1'b0;
      os_tick_q   <= 1'b0;
      baud_tick_q <= 1'b0;
      mid_tick_q  <= 1'b0;
`ifdef UART_BAUD_FRAC_EN
      div_frac_q  <= DEF_FRAC;
      pend_frac_q <= '0;
      acc_q       <= '0;
      ext_q       <= 1'b0;
`endif
    end else begin
      div_int_q   <= div_int_d;
      pend_int_q  <= pend_int_d;
      cnt_q       <= cnt_d;
      os_cnt_q    <= os_cnt_d;
      pend_q      <= pend_d;
      cfg_ready_q <= cfg_ready_d;
      cfg_err_q   <= cfg_err_d;
      os_tick_q   <= os_tick_d;
      baud_tick_q <= baud_tick_d;
      mid_tick_q  <= mid_tick_d;
`ifdef UART_BAUD_FRAC_EN
      div_frac_q  <= div_frac_d;
      pend_frac_q <= pend_frac_d;
      acc_q       <= acc_d;
      ext_q       <= ext_d;
`endif
    end
  end

  assign cfg_ready = cfg_ready_q;
  assign cfg_err   = cfg_err_q;
  assign os_tick   = os_tick_q;
  assign baud_tick = baud_tick_q;
  assign mid_tick  = mid_tick_q;

endmodule

// File: tb/tb_uart_baud_gen_os.sv
// Bench for uart_baud_gen_os: tick events are logged as (cycle, kind) and
// compared in order against expected events queued when stimulus is applied.
module tb_uart_baud_gen_os;

`ifdef UART_BAUD_FRAC_EN
  localparam int DEF_INT  = 325;
  localparam int DEF_FRAC = 8;
`else
  localparam int DEF_INT  = 326;
  localparam int DEF_FRAC = 0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        restart = 1'b0;
  logic [15:0] cfg_div_int = '0;
  logic [3:0]  cfg_div_frac = '0;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready, os_tick, baud_tick, mid_tick, cfg_err;

  int checks = 0;
  int errors = 0;
  int ec = 0;
  int base = 0;
  int obs_ev[$];
  int exp_ev[$];

  uart_baud_gen_os dut (
    .clk(clk), .rst(rst), .en(en), .restart(restart),
    .cfg_div_int(cfg_div_int), .cfg_div_frac(cfg_div_frac), .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready), .os_tick(os_tick), .baud_tick(baud_tick),
    .mid_tick(mid_tick), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) ec <= ec + 1;

  // Event log: cycle*4 + kind (0 os, 1 baud, 2 mid), cycle 1 = first cycle after rst falls.
  always @(negedge clk) begin
    if (!rst) begin
      if (os_tick)   obs_ev.push_back((ec - base + 1) * 4 + 0);
      if (baud_tick) obs_ev.push_back((ec - base + 1) * 4 + 1);
      if (mid_tick)  obs_ev.push_back((ec - base + 1) * 4 + 2);
    end
  end

  // Cycle of the k-th os_tick after reset with the default divisor.
  function automatic int def_tick(input int k);
    return k * DEF_INT + ((k - 1) * DEF_FRAC) / 16 + 1;
  endfunction

  task automatic push_ev(input int cyc, input bit b, input bit m);
    exp_ev.push_back(cyc * 4 + 0);
    if (b) exp_ev.push_back(cyc * 4 + 1);
    if (m) exp_ev.push_back(cyc * 4 + 2);
  endtask

  // Leaves the caller just after the clock edge that starts cycle c.
  task automatic goto_cycle(input int c);
    while ((ec - base + 1) < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset(input logic en_v);
    @(posedge clk);
    #1;
    rst = 1'b1; restart = 1'b0; cfg_valid = 1'b0; en = en_v;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    base = ec;
    obs_ev.delete();
    exp_ev.delete();
  endtask

  task automatic test_reset;
    @(posedge clk);
    #1;
    rst = 1'b1; en = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (os_tick !== 1'b0)   begin errors++; $display("FAIL reset_os_tick got %b need 0", os_tick); end
    checks++; if (baud_tick !== 1'b0) begin errors++; $display("FAIL reset_baud_tick got %b need 0", baud_tick); end
    checks++; if (mid_tick !== 1'b0)  begin errors++; $display("FAIL reset_mid_tick got %b need 0", mid_tick); end
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL reset_cfg_ready got %b need 1", cfg_ready); end
    checks++; if (cfg_err !== 1'b0)   begin errors++; $display("FAIL reset_cfg_err got %b need 0", cfg_err); end
  endtask

  task automatic test_default;
    int e, o;
    do_reset(1'b1);
    for (int k = 1; k <= 32; k++) push_ev(def_tick(k), (k % 16) == 0, (k % 16) == 8);
    goto_cycle(def_tick(32) + 2);
    while (exp_ev.size() > 0) begin
      e = exp_ev.pop_front();
      checks++;
      if (obs_ev.size() == 0) begin
        errors++; $display("FAIL default_ticks got none need cyc %0d kind %0d", e >> 2, e & 3);
      end else begin
        o = obs_ev.pop_front();
        if (o !== e) begin errors++; $display("FAIL default_ticks got cyc %0d kind %0d need cyc %0d kind %0d", o >> 2, o & 3, e >> 2, e & 3); end
      end
    end
  endtask

  task automatic test_cfg_change;
    int e, o;
    int w;
    do_reset(1'b1);
    w = DEF_INT;  // first period ends in cycle DEF_INT (accumulator starts empty)
    goto_cycle(100);
    cfg_valid = 1'b1; cfg_div_int = 16'd10; cfg_div_frac = 4'd0;
    goto_cycle(101);
    cfg_valid = 1'b0;
    @(negedge clk);
    checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL cfg_ready_pending got %b need 0", cfg_ready); end
    goto_cycle(w);
    @(negedge clk);
    checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL cfg_ready_at_wrap got %b need 0", cfg_ready); end
    goto_cycle(w + 1);
    @(negedge clk);
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL cfg_ready_after_apply got %b need 1", cfg_ready); end
    for (int j = 1; j <= 20; j++) push_ev(w + 1 + 10 * (j - 1), ((j - 1) % 16) == 15, ((j - 1) % 16) == 7);
    goto_cycle(w + 1 + 190 + 2);
    while (exp_ev.size() > 0) begin
      e = exp_ev.pop_front();
      checks++;
      if (obs_ev.size() == 0) begin
        errors++; $display("FAIL cfg10_ticks got none need cyc %0d kind %0d", e >> 2, e & 3);
      end else begin
        o = obs_ev.pop_front();
        if (o !== e) begin errors++; $display("FAIL cfg10_ticks got cyc %0d kind %0d need cyc %0d kind %0d", o >> 2, o & 3, e >> 2, e & 3); end
      end
    end
  endtask

  task automatic test_cfg_err;
    int e, o;
    do_reset(1'b1);
    goto_cycle(50);
    cfg_valid = 1'b1; cfg_div_int = 16'd1; cfg_div_frac = 4'd3;
    @(negedge clk);
    checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL cfg_err_early got %b need 0", cfg_err); end
    goto_cycle(51);
    cfg_valid = 1'b0;
    @(negedge clk);
    checks++; if (cfg_err !== 1'b1)   begin errors++; $display("FAIL cfg_err_rise got %b need 1", cfg_err); end
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL cfg_err_ready got %b need 1", cfg_ready); end
    for (int k = 1; k <= 8; k++) push_ev(def_tick(k), 1'b0, k == 8);
    goto_cycle(def_tick(8) + 2);
    while (exp_ev.size() > 0) begin
      e = exp_ev.pop_front();
      checks++;
      if (obs_ev.size() == 0) begin
        errors++; $display("FAIL cfg_err_ticks got none need cyc %0d kind %0d", e >> 2, e & 3);
      end else begin
        o = obs_ev.pop_front();
        if (o !== e) begin errors++; $display("FAIL cfg_err_ticks got cyc %0d kind %0d need cyc %0d kind %0d", o >> 2, o & 3, e >> 2, e & 3); end
      end
    end
    @(negedge clk);
    checks++; if (cfg_err !== 1'b1) begin errors++; $display("FAIL cfg_err_sticky got %b need 1", cfg_err); end
  endtask

  task automatic test_restart;
    int e, o;
    int t, t2;
    do_reset(1'b0);
    goto_cycle(2);
    cfg_valid = 1'b1; cfg_div_int = 16'd10; cfg_div_frac = 4'd0;
    goto_cycle(3);
    cfg_valid = 1'b0;
    goto_cycle(10);
    en = 1'b1;
    t = 37;
    goto_cycle(t);
    restart = 1'b1;
    goto_cycle(t + 1);
    restart = 1'b0;
    obs_ev.delete();
    for (int j = 1; j <= 16; j++) push_ev(t + 1 + 10 * j, j == 16, j == 8);
    // Restart together with a new request: divisor 6 takes effect immediately.
    t2 = t + 170;
    goto_cycle(t2);
    restart = 1'b1; cfg_valid = 1'b1; cfg_div_int = 16'd6;
    goto_cycle(t2 + 1);
    restart = 1'b0; cfg_valid = 1'b0;
    @(negedge clk);
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL restart_cfg_ready got %b need 1", cfg_ready); end
    for (int j = 1; j <= 8; j++) push_ev(t2 + 1 + 6 * j, 1'b0, j == 8);
    goto_cycle(t2 + 52);
    while (exp_ev.size() > 0) begin
      e = exp_ev.pop_front();
      checks++;
      if (obs_ev.size() == 0) begin
        errors++; $display("FAIL restart_ticks got none need cyc %0d kind %0d", e >> 2, e & 3);
      end else begin
        o = obs_ev.pop_front();
        if (o !== e) begin errors++; $display("FAIL restart_ticks got cyc %0d kind %0d need cyc %0d kind %0d", o >> 2, o & 3, e >> 2, e & 3); end
      end
    end
  endtask

  task automatic test_en_gap;
    int e, o;
    int gap_cnt;
    do_reset(1'b0);
    goto_cycle(2);
    cfg_valid = 1'b1; cfg_div_int = 16'd10; cfg_div_frac = 4'd0;
    goto_cycle(3);
    cfg_valid = 1'b0;
    goto_cycle(5);
    en = 1'b1; restart = 1'b1;
    goto_cycle(6);
    restart = 1'b0;
    goto_cycle(40);
    en = 1'b0;
    goto_cycle(90);
    en = 1'b1;
    // Without the gap ticks would be 46, 56; a 50-cycle hold shifts them to 96, 106.
    push_ev(16, 1'b0, 1'b0);
    push_ev(26, 1'b0, 1'b0);
    push_ev(36, 1'b0, 1'b0);
    push_ev(96, 1'b0, 1'b0);
    push_ev(106, 1'b0, 1'b0);
    goto_cycle(110);
    gap_cnt = 0;
    foreach (obs_ev[i]) if ((obs_ev[i] >> 2) >= 41 && (obs_ev[i] >> 2) <= 95) gap_cnt++;
    checks++; if (gap_cnt !== 0) begin errors++; $display("FAIL en_gap_quiet got %0d ticks need 0", gap_cnt); end
    while (exp_ev.size() > 0) begin
      e = exp_ev.pop_front();
      checks++;
      if (obs_ev.size() == 0) begin
        errors++; $display("FAIL en_gap_ticks got none need cyc %0d kind %0d", e >> 2, e & 3);
      end else begin
        o = obs_ev.pop_front();
        if (o !== e) begin errors++; $display("FAIL en_gap_ticks got cyc %0d kind %0d need cyc %0d kind %0d", o >> 2, o & 3, e >> 2, e & 3); end
      end
    end
  endtask

  task automatic test_reset_drops_pending;
    int e, o;
    do_reset(1'b1);
    goto_cycle(50);
    cfg_valid = 1'b1; cfg_div_int = 16'd10; cfg_div_frac = 4'd0;
    goto_cycle(51);
    cfg_valid = 1'b0;
    @(negedge clk);
    checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL pend_before_rst got %b need 0", cfg_ready); end
    goto_cycle(60);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    base = ec;
    obs_ev.delete();
    @(negedge clk);
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL pend_after_rst got %b need 1", cfg_ready); end
    push_ev(def_tick(1), 1'b0, 1'b0);
    push_ev(def_tick(2), 1'b0, 1'b0);
    goto_cycle(def_tick(2) + 2);
    while (exp_ev.size() > 0) begin
      e = exp_ev.pop_front();
      checks++;
      if (obs_ev.size() == 0) begin
        errors++; $display("FAIL rst_pend_ticks got none need cyc %0d kind %0d", e >> 2, e & 3);
      end else begin
        o = obs_ev.pop_front();
        if (o !== e) begin errors++; $display("FAIL rst_pend_ticks got cyc %0d kind %0d need cyc %0d kind %0d", o >> 2, o & 3, e >> 2, e & 3); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_default();
    test_cfg_change();
    test_cfg_err();
    test_restart();
    test_en_gap();
    test_reset_drops_pending();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
